// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests under a credit limit,
// buffers in-order responses for decode, and squashes stale work on a redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] pf_wr_q, pf_wr_d;
  logic [PTR_W-1:0] pf_rd_q, pf_rd_d;

  logic [31:0] buf_inst_q [BUF_DEPTH];
  logic [31:0] buf_pc_q   [BUF_DEPTH];
  logic [31:0] pf_pc_q    [BUF_DEPTH];

  logic [8:0] inflight;
  logic       req_fire;
  logic       pop_fire;
  logic       push_fire;
  logic [1:0] unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // drop_q never exceeds pend_q, so the in-flight total cannot underflow
  assign inflight       = 9'(buf_cnt_q) + 9'(pend_q) - 9'(drop_q);
  assign imem_req_valid = !redirect_valid && (inflight < 9'(BUF_DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (buf_cnt_q != '0);
  assign inst       = inst_valid ? buf_inst_q[rd_ptr_q] : 32'h0000_0013;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;
  assign pop_fire   = inst_valid && inst_ready;
  assign push_fire  = imem_rsp_valid && (drop_q == '0) &&
                      (buf_cnt_q != CNT_W'(BUF_DEPTH)) && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q + 8'(req_fire) - 8'(imem_rsp_valid);
    drop_d     = drop_q;
    buf_cnt_d  = buf_cnt_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_fire);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_fire);
    pf_wr_d    = pf_wr_q + PTR_W'(req_fire);
    pf_rd_d    = pf_rd_q + PTR_W'(imem_rsp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 8'd1;
    end

    // Everything still outstanding after this cycle belongs to the old path
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = pend_d;
      buf_cnt_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      buf_cnt_q  <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      buf_cnt_q  <= buf_cnt_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
    end
  end

  // Storage carries no reset; validity is tracked by the counters above
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pf_pc_q[pf_wr_q] <= fetch_pc_q;
    end
    if (push_fire) begin
      buf_inst_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= pf_pc_q[pf_rd_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: in-order memory model with adjustable latency,
// logs of accepted requests and decode pops, immediate-assertion checks.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  inst_fetch #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int lat = 1;
  int cyc = 0;
  int last_due = 0;
  int due;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        mq[$];
  logic [31:0] acc_log[$];
  logic [63:0] pop_log[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  // Memory response for the current cycle is driven just after the rising edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mq[0].addr);
      mq.delete(0);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_due = cyc;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{imem_addr, due});
        acc_log.push_back(imem_addr);
      end
      if (inst_valid && inst_ready && !redirect_valid) pop_log.push_back({inst, inst_pc});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int          mark_a;
  int          mark_p;
  logic        found;
  logic [31:0] ptmp;

  initial begin
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset values
    repeat (3) step();
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h13);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Release: accept 0x100 in cycle 0, head valid in cycle 2
    rst_n = 1'b1;
    #1;
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_addr", imem_addr, 32'h100);
    step(); #1;
    check("c1_addr", imem_addr, 32'h104);
    check("c1_inst_valid", 32'(inst_valid), 32'd0);
    step(); #1;
    check("c2_inst_valid", 32'(inst_valid), 32'd1);
    check("c2_inst_pc", inst_pc, 32'h100);
    check("c2_inst", inst, mdata(32'h100));
    repeat (20) step();

    // Backpressure: buffer fills, requests stop
    inst_ready = 1'b0;
    repeat (10) step();
    #1;
    check("bp_inst_valid", 32'(inst_valid), 32'd1);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_head_pc", inst_pc, 32'h100 + 32'(4 * pop_log.size()));
    inst_ready = 1'b1;
    repeat (20) step();
    check("seq_pop_count", 32'(pop_log.size() >= 16), 32'd1);
    foreach (pop_log[i]) begin
      ptmp = 32'h100 + 32'(4 * i);
      check($sformatf("seq_pop_pc[%0d]", i), pop_log[i][31:0], ptmp);
      check($sformatf("seq_pop_inst[%0d]", i), pop_log[i][63:32], mdata(ptmp));
    end
    foreach (acc_log[i]) check($sformatf("seq_acc[%0d]", i), acc_log[i], 32'h100 + 32'(4 * i));

    // Latency 3: two outstanding (0x200, 0x204) squashed by redirect to 0x403
    lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (acc_log.size() > 0 && acc_log[acc_log.size()-1] == 32'h204) found = 1'b1;
      else step();
    end
    check("l3_204_issued", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h403;
    mark_a = acc_log.size();
    mark_p = pop_log.size();
    #1;
    check("l3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("l3_next_req_valid", 32'(imem_req_valid), 32'd1);
    check("l3_next_addr", imem_addr, 32'h400);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (pop_log.size() > mark_p) found = 1'b1;
      else step();
    end
    check("l3_pop_seen", 32'(found), 32'd1);
    check("l3_first_pc", pop_log[mark_p][31:0], 32'h400);
    check("l3_first_inst", pop_log[mark_p][63:32], mdata(32'h400));
    check("l3_first_acc", acc_log[mark_a], 32'h400);

    // Redirect coinciding with a response and a pop
    lat = 1;
    repeat (8) step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_rsp_valid && inst_valid) found = 1'b1;
      else step();
    end
    check("co_window_found", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h800;
    mark_p = pop_log.size();
    #1;
    check("co_redir_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("co_inst_valid", 32'(inst_valid), 32'd0);
    check("co_req_valid", 32'(imem_req_valid), 32'd1);
    check("co_addr", imem_addr, 32'h800);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (pop_log.size() > mark_p) found = 1'b1;
      else step();
    end
    check("co_pop_seen", 32'(found), 32'd1);
    check("co_first_pc", pop_log[mark_p][31:0], 32'h800);

    // Fetch PC wrap-around
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    mark_a = acc_log.size();
    mark_p = pop_log.size();
    step();
    redirect_valid = 1'b0;
    repeat (15) step();
    check("wr_acc_count", 32'(acc_log.size() >= mark_a + 3), 32'd1);
    check("wr_pop_count", 32'(pop_log.size() >= mark_p + 3), 32'd1);
    check("wr_acc0", acc_log[mark_a], 32'hFFFF_FFF8);
    check("wr_acc1", acc_log[mark_a+1], 32'hFFFF_FFFC);
    check("wr_acc2", acc_log[mark_a+2], 32'h0000_0000);
    check("wr_pop0", pop_log[mark_p][31:0], 32'hFFFF_FFF8);
    check("wr_pop1", pop_log[mark_p+1][31:0], 32'hFFFF_FFFC);
    check("wr_pop2", pop_log[mark_p+2][31:0], 32'h0000_0000);
    check("wr_pop2_inst", pop_log[mark_p+2][63:32], mdata(32'h0));

    // Asynchronous reset mid-operation
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (inst_valid) found = 1'b1;
      else step();
    end
    check("mr_busy_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_inst_valid", 32'(inst_valid), 32'd0);
    check("mr_inst", inst, 32'h13);
    check("mr_inst_pc", inst_pc, 32'h0);
    check("mr_addr", imem_addr, 32'h100);
    repeat (2) step();
    lat = 1;
    mark_a = acc_log.size();
    mark_p = pop_log.size();
    rst_n = 1'b1;
    repeat (15) step();
    check("mr_acc_count", 32'(acc_log.size() > mark_a), 32'd1);
    check("mr_pop_count", 32'(pop_log.size() > mark_p), 32'd1);
    check("mr_first_acc", acc_log[mark_a], 32'h100);
    check("mr_first_pc", pop_log[mark_p][31:0], 32'h100);
    check("mr_first_inst", pop_log[mark_p][63:32], mdata(32'h100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
